// File: rtl/ts_cc_monitor.sv
// TS header parser and continuity-counter monitor: extracts TEI/PID/AFC/CC from
// each aligned packet, checks CC continuity per PID and counts QoS errors.
module ts_cc_monitor #(
  parameter int NUM_PIDS = 8,
  parameter int PKT_LEN  = 188,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  input  logic             pkt_start,
  output logic             hdr_valid,
  output logic [12:0]      hdr_pid,
  output logic [3:0]       hdr_cc,
  output logic [1:0]       hdr_afc,
  output logic             cc_err,
  output logic             tei_err,
  output logic             len_err,
  output logic             table_full,
  output logic [CNT_W-1:0] cc_err_cnt,
  output logic [CNT_W-1:0] tei_err_cnt
);

  localparam int IDX_W = (NUM_PIDS > 1) ? $clog2(NUM_PIDS) : 1;
  localparam int POS_W = $clog2(PKT_LEN);
  localparam logic [12:0] NULL_PID = 13'h1FFF;
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(PKT_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_H1   = 3'd1,
    S_H2   = 3'd2,
    S_H3   = 3'd3,
    S_PAY  = 3'd4
  } state_t;

  state_t           state_q;
  logic [POS_W-1:0] pos_q;
  logic             len_err_q;

  logic             h_tei_q;
  logic [4:0]       h_pid_hi_q;
  logic [7:0]       h_pid_lo_q;

  logic             fld_vld_q;
  logic             fld_tei_q;
  logic [12:0]      fld_pid_q;
  logic [1:0]       fld_afc_q;
  logic [3:0]       fld_cc_q;

  // Parser: header bytes are held until H3 so the fields update atomically.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pos_q      <= '0;
      len_err_q  <= 1'b0;
      h_tei_q    <= 1'b0;
      h_pid_hi_q <= '0;
      h_pid_lo_q <= '0;
      fld_vld_q  <= 1'b0;
      fld_tei_q  <= 1'b0;
      fld_pid_q  <= '0;
      fld_afc_q  <= '0;
      fld_cc_q   <= '0;
    end else begin
      fld_vld_q <= 1'b0;
      len_err_q <= 1'b0;
      if (byte_valid) begin
        if (pkt_start) begin
          len_err_q <= (state_q != S_IDLE);
          state_q   <= S_H1;
          pos_q     <= POS_W'(1);
        end else begin
          case (state_q)
            S_IDLE: begin
              state_q <= S_IDLE;
            end
            S_H1: begin
              h_tei_q    <= byte_in[7];
              h_pid_hi_q <= byte_in[4:0];
              state_q    <= S_H2;
              pos_q      <= pos_q + POS_W'(1);
            end
            S_H2: begin
              h_pid_lo_q <= byte_in;
              state_q    <= S_H3;
              pos_q      <= pos_q + POS_W'(1);
            end
            S_H3: begin
              fld_vld_q <= 1'b1;
              fld_tei_q <= h_tei_q;
              fld_pid_q <= {h_pid_hi_q, h_pid_lo_q};
              fld_afc_q <= byte_in[5:4];
              fld_cc_q  <= byte_in[3:0];
              state_q   <= S_PAY;
              pos_q     <= pos_q + POS_W'(1);
            end
            S_PAY: begin
              if (pos_q == LAST_POS) begin
                state_q <= S_IDLE;
                pos_q   <= '0;
              end else begin
                pos_q <= pos_q + POS_W'(1);
              end
            end
            default: begin
              state_q <= S_IDLE;
              pos_q   <= '0;
            end
          endcase
        end
      end
    end
  end

  logic [NUM_PIDS-1:0] tab_vld_q;
  logic [12:0]         tab_pid_q [NUM_PIDS];
  logic [3:0]          tab_cc_q  [NUM_PIDS];

  logic [NUM_PIDS-1:0] match_vec;
  logic [NUM_PIDS-1:0] free_vec;

  generate
    for (genvar gi = 0; gi < NUM_PIDS; gi++) begin : g_cmp
      assign match_vec[gi] = tab_vld_q[gi] && (tab_pid_q[gi] == fld_pid_q);
      assign free_vec[gi]  = !tab_vld_q[gi];
    end
  endgenerate

  logic [IDX_W-1:0] hit_idx_d;
  logic [IDX_W-1:0] free_idx_d;

  // Descending scan so the lowest matching / free index wins.
  always_comb begin
    hit_idx_d  = '0;
    free_idx_d = '0;
    for (int i = NUM_PIDS - 1; i >= 0; i--) begin
      if (match_vec[i]) hit_idx_d = IDX_W'(i);
      if (free_vec[i])  free_idx_d = IDX_W'(i);
    end
  end

  logic             lk_vld_q;
  logic             lk_hit_q;
  logic             lk_free_q;
  logic [IDX_W-1:0] lk_hit_idx_q;
  logic [IDX_W-1:0] lk_free_idx_q;
  logic [3:0]       lk_last_cc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lk_vld_q      <= 1'b0;
      lk_hit_q      <= 1'b0;
      lk_free_q     <= 1'b0;
      lk_hit_idx_q  <= '0;
      lk_free_idx_q <= '0;
      lk_last_cc_q  <= '0;
    end else begin
      lk_vld_q      <= fld_vld_q;
      lk_hit_q      <= |match_vec;
      lk_free_q     <= |free_vec;
      lk_hit_idx_q  <= hit_idx_d;
      lk_free_idx_q <= free_idx_d;
      lk_last_cc_q  <= tab_cc_q[hit_idx_d];
    end
  end

  logic             is_null;
  logic             cc_ok;
  logic             cc_err_d;
  logic             tei_err_d;
  logic             full_d;
  logic             wr_en_d;
  logic [IDX_W-1:0] wr_idx_d;

  assign is_null = (fld_pid_q == NULL_PID);

  always_comb begin
    cc_ok     = 1'b1;
    cc_err_d  = 1'b0;
    tei_err_d = lk_vld_q && fld_tei_q;
    full_d    = table_full;
    wr_en_d   = 1'b0;
    wr_idx_d  = '0;
    if (fld_afc_q[0]) begin
      // Payload present: increment expected, repeat tolerated as a duplicate.
      cc_ok = (fld_cc_q == lk_last_cc_q) || (fld_cc_q == 4'(lk_last_cc_q + 4'd1));
    end else begin
      cc_ok = (fld_cc_q == lk_last_cc_q);
    end
    if (lk_vld_q && !is_null) begin
      if (lk_hit_q) begin
        cc_err_d = !cc_ok;
        wr_en_d  = 1'b1;
        wr_idx_d = lk_hit_idx_q;
      end else if (lk_free_q) begin
        wr_en_d  = 1'b1;
        wr_idx_d = lk_free_idx_q;
      end else begin
        full_d = 1'b1;
      end
    end
  end

  logic             hdr_valid_q;
  logic [12:0]      hdr_pid_q;
  logic [3:0]       hdr_cc_q;
  logic [1:0]       hdr_afc_q;
  logic             cc_err_q;
  logic             tei_err_q;
  logic             table_full_q;
  logic [CNT_W-1:0] cc_err_cnt_q;
  logic [CNT_W-1:0] tei_err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_valid_q   <= 1'b0;
      hdr_pid_q     <= '0;
      hdr_cc_q      <= '0;
      hdr_afc_q     <= '0;
      cc_err_q      <= 1'b0;
      tei_err_q     <= 1'b0;
      table_full_q  <= 1'b0;
      cc_err_cnt_q  <= '0;
      tei_err_cnt_q <= '0;
      tab_vld_q     <= '0;
    end else begin
      hdr_valid_q  <= lk_vld_q;
      cc_err_q     <= cc_err_d;
      tei_err_q    <= tei_err_d;
      table_full_q <= full_d;
      if (lk_vld_q) begin
        hdr_pid_q <= fld_pid_q;
        hdr_cc_q  <= fld_cc_q;
        hdr_afc_q <= fld_afc_q;
      end
      if (cc_err_d && (cc_err_cnt_q != '1)) cc_err_cnt_q <= cc_err_cnt_q + CNT_W'(1);
      if (tei_err_d && (tei_err_cnt_q != '1)) tei_err_cnt_q <= tei_err_cnt_q + CNT_W'(1);
      if (wr_en_d) tab_vld_q[wr_idx_d] <= 1'b1;
    end
  end

  // Table payload needs no reset: entries are qualified by tab_vld_q.
  always_ff @(posedge clk) begin
    if (wr_en_d) begin
      tab_pid_q[wr_idx_d] <= fld_pid_q;
      tab_cc_q[wr_idx_d]  <= fld_cc_q;
    end
  end

  assign hdr_valid   = hdr_valid_q;
  assign hdr_pid     = hdr_pid_q;
  assign hdr_cc      = hdr_cc_q;
  assign hdr_afc     = hdr_afc_q;
  assign cc_err      = cc_err_q;
  assign tei_err     = tei_err_q;
  assign len_err     = len_err_q;
  assign table_full  = table_full_q;
  assign cc_err_cnt  = cc_err_cnt_q;
  assign tei_err_cnt = tei_err_cnt_q;

endmodule

// File: tb/tb_ts_cc_monitor.sv
// Bench for ts_cc_monitor: table-driven header vectors, directed corner cases and
// randomized packet streams checked against a per-PID CC model.
module tb_ts_cc_monitor;

  localparam int NUM_PIDS = 8;
  localparam int PKT_LEN  = 188;
  localparam int CNT_W    = 16;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       byte_in = '0;
  logic             byte_valid = 1'b0;
  logic             pkt_start = 1'b0;
  logic             hdr_valid;
  logic [12:0]      hdr_pid;
  logic [3:0]       hdr_cc;
  logic [1:0]       hdr_afc;
  logic             cc_err;
  logic             tei_err;
  logic             len_err;
  logic             table_full;
  logic [CNT_W-1:0] cc_err_cnt;
  logic [CNT_W-1:0] tei_err_cnt;

  ts_cc_monitor #(.NUM_PIDS(NUM_PIDS), .PKT_LEN(PKT_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .pkt_start(pkt_start), .hdr_valid(hdr_valid), .hdr_pid(hdr_pid),
    .hdr_cc(hdr_cc), .hdr_afc(hdr_afc), .cc_err(cc_err), .tei_err(tei_err),
    .len_err(len_err), .table_full(table_full), .cc_err_cnt(cc_err_cnt),
    .tei_err_cnt(tei_err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [12:0] pid;
    logic [3:0]  cc;
    logic [1:0]  afc;
    logic        cc_err;
    logic        tei_err;
  } exp_t;

  typedef struct {
    logic [12:0] pid;
    logic        tei;
    logic [1:0]  afc;
    logic [3:0]  cc;
    logic        e_cc;
    logic        e_tei;
    int          e_ccnt;
    int          e_tcnt;
  } vec_t;

  exp_t exp_q[$];
  int   len_q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_hdr = 0;

  logic [3:0] m_cc [int];
  int   m_n = 0;
  logic m_full = 1'b0;
  int   m_cc_cnt = 0;
  int   m_tei_cnt = 0;
  bit   in_pkt = 1'b0;
  int   gap_pct = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Per-PID last-CC memory with a capacity limit; returns the expected cc_err.
  function automatic logic model_hdr(input logic [12:0] pid, input logic tei,
                                     input logic [1:0] afc, input logic [3:0] cc);
    logic       err;
    logic [3:0] last;
    int         nxt;
    err = 1'b0;
    if (tei && m_tei_cnt < CNT_MAX) m_tei_cnt++;
    if (pid != 13'h1FFF) begin
      if (m_cc.exists(int'(pid))) begin
        last = m_cc[int'(pid)];
        nxt  = (int'(last) + 1) % 16;
        if (afc[0]) err = !((int'(cc) == nxt) || (cc == last));
        else        err = (cc != last);
        m_cc[int'(pid)] = cc;
      end else if (m_n < NUM_PIDS) begin
        m_cc[int'(pid)] = cc;
        m_n++;
      end else begin
        m_full = 1'b1;
      end
    end
    if (err && m_cc_cnt < CNT_MAX) m_cc_cnt++;
    return err;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (hdr_valid) begin
        if (exp_q.size() == 0) begin
          chk("hdr_unexpected", 32'(hdr_valid), 0);
        end else begin
          mon_e = exp_q.pop_front();
          n_hdr++;
          chk("hdr_latency", cyc, mon_e.due);
          chk("hdr_pid", 32'(hdr_pid), 32'(mon_e.pid));
          chk("hdr_cc", 32'(hdr_cc), 32'(mon_e.cc));
          chk("hdr_afc", 32'(hdr_afc), 32'(mon_e.afc));
          chk("cc_err", 32'(cc_err), 32'(mon_e.cc_err));
          chk("tei_err", 32'(tei_err), 32'(mon_e.tei_err));
          $display("hdr %0d: cyc=%0d pid=0x%03h cc=%0d afc=%0d cc_err=%0b tei_err=%0b",
                   n_hdr, cyc, hdr_pid, hdr_cc, hdr_afc, cc_err, tei_err);
        end
      end else begin
        if (cc_err || tei_err) chk("stray_err", 32'({cc_err, tei_err}), 0);
        if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
          chk("hdr_missing", 32'(hdr_valid), 1);
          void'(exp_q.pop_front());
        end
      end
      if (len_err || (len_q.size() != 0 && len_q[0] <= cyc)) begin
        chk("len_err", 32'(len_err), 32'(len_q.size() != 0 && len_q[0] == cyc));
        if (len_q.size() != 0 && len_q[0] <= cyc) void'(len_q.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    byte_valid = 1'b0;
    pkt_start  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put(input logic [7:0] b, input logic s);
    while ($urandom_range(0, 99) < gap_pct) begin
      byte_valid = 1'b0;
      byte_in    = 8'($urandom);
      pkt_start  = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    byte_in    = b;
    byte_valid = 1'b1;
    pkt_start  = s;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    pkt_start  = 1'b0;
  endtask

  task automatic send_pkt(input logic [12:0] pid, input logic tei, input logic [1:0] afc,
                          input logic [3:0] cc, input int nbytes, input bit tbl,
                          input logic t_cc, input logic t_tei);
    logic [7:0] hb [4];
    logic [7:0] b;
    logic       err;
    bit         was_in;
    exp_t       e;
    hb[0]  = 8'h47;
    hb[1]  = {tei, 2'($urandom), pid[12:8]};
    hb[2]  = pid[7:0];
    hb[3]  = {2'($urandom), afc, cc};
    was_in = in_pkt;
    for (int i = 0; i < nbytes; i++) begin
      b = (i < 4) ? hb[i] : 8'($urandom);
      put(b, i == 0);
      if (i == 0) begin
        if (was_in) len_q.push_back(cyc);
        in_pkt = 1'b1;
      end
      if (i == 3) begin
        err       = model_hdr(pid, tei, afc, cc);
        e.due     = cyc + 2;
        e.pid     = pid;
        e.cc      = cc;
        e.afc     = afc;
        e.cc_err  = tbl ? t_cc : err;
        e.tei_err = tbl ? t_tei : tei;
        exp_q.push_back(e);
      end
    end
    if (nbytes == PKT_LEN) in_pkt = 1'b0;
  endtask

  task automatic do_reset(input int n);
    exp_q.delete();
    len_q.delete();
    rst        = 1'b1;
    byte_valid = 1'b0;
    pkt_start  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    chk("rst_hdr_valid", 32'(hdr_valid), 0);
    chk("rst_hdr_pid", 32'(hdr_pid), 0);
    chk("rst_hdr_cc", 32'(hdr_cc), 0);
    chk("rst_hdr_afc", 32'(hdr_afc), 0);
    chk("rst_cc_err", 32'(cc_err), 0);
    chk("rst_tei_err", 32'(tei_err), 0);
    chk("rst_len_err", 32'(len_err), 0);
    chk("rst_table_full", 32'(table_full), 0);
    chk("rst_cc_err_cnt", 32'(cc_err_cnt), 0);
    chk("rst_tei_err_cnt", 32'(tei_err_cnt), 0);
    rst = 1'b0;
    m_cc.delete();
    m_n       = 0;
    m_full    = 1'b0;
    m_cc_cnt  = 0;
    m_tei_cnt = 0;
    in_pkt    = 1'b0;
  endtask

  task automatic check_state(input string tag);
    idle(4);
    chk({tag, "_table_full"}, 32'(table_full), 32'(m_full));
    chk({tag, "_cc_err_cnt"}, 32'(cc_err_cnt), 32'(m_cc_cnt));
    chk({tag, "_tei_err_cnt"}, 32'(tei_err_cnt), 32'(m_tei_cnt));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[$];
    vec_t       v;
    logic [3:0] last_sent [11];
    logic [12:0] pid;
    logic [3:0]  cc;
    int          idx;
    int          r;
    int          nb;

    for (int i = 0; i < 17; i++)
      vecs.push_back('{13'h100, 1'b0, 2'b01, 4'(i % 16), 1'b0, 1'b0, (i == 16) ? 0 : -1, 0});
    vecs.push_back('{13'h101, 1'b0, 2'b01, 4'd3, 1'b0, 1'b0, -1, 0});
    vecs.push_back('{13'h101, 1'b0, 2'b01, 4'd4, 1'b0, 1'b0, -1, 0});
    vecs.push_back('{13'h101, 1'b0, 2'b01, 4'd6, 1'b1, 1'b0,  1, 0});
    vecs.push_back('{13'h101, 1'b0, 2'b01, 4'd7, 1'b0, 1'b0,  1, 0});
    vecs.push_back('{13'h102, 1'b0, 2'b01, 4'd5, 1'b0, 1'b0, -1, 0});
    vecs.push_back('{13'h102, 1'b0, 2'b01, 4'd5, 1'b0, 1'b0,  1, 0});
    vecs.push_back('{13'h102, 1'b0, 2'b10, 4'd5, 1'b0, 1'b0,  1, 0});
    vecs.push_back('{13'h102, 1'b0, 2'b10, 4'd6, 1'b1, 1'b0,  2, 0});
    vecs.push_back('{13'h1FFF, 1'b1, 2'b01, 4'd9, 1'b0, 1'b1,  2, 1});

    do_reset(3);
    idle(2);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      send_pkt(v.pid, v.tei, v.afc, v.cc, PKT_LEN, 1'b1, v.e_cc, v.e_tei);
      if (v.e_ccnt >= 0) begin
        idle(4);
        chk("vec_cc_err_cnt", 32'(cc_err_cnt), 32'(v.e_ccnt));
        chk("vec_tei_err_cnt", 32'(tei_err_cnt), 32'(v.e_tcnt));
      end
    end

    // Fill the remaining entries; the null PID above must not have consumed one.
    for (int k = 0; k < NUM_PIDS - 3; k++)
      send_pkt(13'h200 + 13'(k), 1'b0, 2'b01, 4'(k), PKT_LEN, 1'b0, 1'b0, 1'b0);
    idle(4);
    chk("full_before", 32'(table_full), 0);
    send_pkt(13'h200 + 13'(NUM_PIDS), 1'b0, 2'b01, 4'd0, PKT_LEN, 1'b0, 1'b0, 1'b0);
    idle(4);
    chk("full_after", 32'(table_full), 1);
    send_pkt(13'h100, 1'b0, 2'b01, 4'd1, PKT_LEN, 1'b0, 1'b0, 1'b0);
    send_pkt(13'h101, 1'b0, 2'b01, 4'd2, PKT_LEN, 1'b0, 1'b0, 1'b0);
    check_state("full");

    // Reset right after H3: the in-flight check must be discarded.
    send_pkt(13'h300, 1'b1, 2'b01, 4'd0, 4, 1'b0, 1'b0, 1'b0);
    do_reset(2);
    for (int k = 0; k < 10; k++) put(8'($urandom), 1'b0);
    idle(5);
    check_state("post_rst");

    send_pkt(13'h103, 1'b0, 2'b01, 4'd0, 101, 1'b0, 1'b0, 1'b0);
    send_pkt(13'h103, 1'b0, 2'b01, 4'd1, PKT_LEN, 1'b0, 1'b0, 1'b0);
    send_pkt(13'h104, 1'b0, 2'b01, 4'd0, 3, 1'b0, 1'b0, 1'b0);
    send_pkt(13'h104, 1'b0, 2'b01, 4'd7, PKT_LEN, 1'b0, 1'b0, 1'b0);
    send_pkt(13'h105, 1'b0, 2'b01, 4'd0, 1, 1'b0, 1'b0, 1'b0);
    send_pkt(13'h105, 1'b1, 2'b11, 4'd2, PKT_LEN, 1'b0, 1'b0, 1'b0);
    send_pkt(13'h104, 1'b0, 2'b01, 4'd9, PKT_LEN, 1'b0, 1'b0, 1'b0);
    check_state("len");

    do_reset(2);
    gap_pct = 20;
    for (int k = 0; k < 11; k++) last_sent[k] = 4'($urandom);
    for (int p = 0; p < 70; p++) begin
      idx = $urandom_range(0, 10);
      pid = (idx == 10) ? 13'h1FFF : 13'h040 + 13'(idx);
      r   = $urandom_range(0, 9);
      if (r < 5)      cc = last_sent[idx] + 4'd1;
      else if (r < 7) cc = last_sent[idx];
      else            cc = 4'($urandom);
      last_sent[idx] = cc;
      nb = ($urandom_range(0, 9) == 0) ? $urandom_range(1, PKT_LEN - 1) : PKT_LEN;
      send_pkt(pid, 1'($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3)), cc, nb,
               1'b0, 1'b0, 1'b0);
    end
    gap_pct = 0;
    idle(6);
    check_state("final");
    chk("pending_hdr", 32'(exp_q.size()), 0);
    chk("pending_len", 32'(len_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
